// File: rtl/mux_scan_ctrl.sv
// Sequencer for a 4-input two-level gate mux: steps the selectors per channel,
// waits DWELL settle cycles, then samples mux_z into result/valid_mask.
module mux_scan_ctrl #(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [1:0] chan,
    input  logic       stop,
    input  logic       mux_z,
    output logic       select,
    output logic       select_group,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic [3:0] valid_mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_FINISH
    } state_t;

    localparam logic [1:0] MODE_SCAN   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_CONT   = 2'b10;
    localparam logic [3:0] DWELL_M1    = 4'(DWELL - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_mode;
    logic [1:0] r_ch;
    logic       r_stop;

    logic [1:0] w_first_ch;
    logic [1:0] w_next_ch;
    logic       w_last_ch;
    logic       w_cont;
    logic       w_single;
    logic       w_end_run;

    assign w_first_ch = (mode == MODE_SINGLE) ? chan : 2'd0;
    assign w_next_ch  = r_ch + 2'd1;
    assign w_last_ch  = (r_ch == 2'd3);
    assign w_cont     = (r_mode == MODE_CONT);
    assign w_single   = (r_mode == MODE_SINGLE);
    // The stop latch is read before this edge's update, so a stop seen during
    // the ch3 sample only ends the following sweep.
    assign w_end_run  = w_single || (w_last_ch && (!w_cont || r_stop));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_mode       <= MODE_SCAN;
            r_ch         <= 2'd0;
            r_stop       <= 1'b0;
            select       <= 1'b0;
            select_group <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= 4'b0000;
            valid_mask   <= 4'b0000;
        end else begin
            done <= 1'b0;
            if (busy && w_cont && stop) begin
                r_stop <= 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode       <= (mode == 2'b11) ? MODE_SCAN : mode;
                        r_ch         <= w_first_ch;
                        select_group <= w_first_ch[1];
                        select       <= w_first_ch[0];
                        result       <= 4'b0000;
                        valid_mask   <= 4'b0000;
                        r_cnt        <= DWELL_M1;
                        r_stop       <= 1'b0;
                        busy         <= 1'b1;
                        r_state      <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_SAMPLE: begin
                    result[r_ch]     <= mux_z;
                    valid_mask[r_ch] <= 1'b1;
                    if (w_end_run) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        // Continuous wrap reports a completed sweep without dropping busy.
                        if (w_last_ch) begin
                            done <= 1'b1;
                        end
                        r_ch         <= w_next_ch;
                        select_group <= w_next_ch[1];
                        select       <= w_next_ch[0];
                        r_cnt        <= DWELL_M1;
                        r_state      <= S_SETTLE;
                    end
                end

                S_FINISH: begin
                    r_stop  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three DUTs (DWELL=1,2,3) share stimulus; a cycle-count
// model predicts every output and directed tests pin key values by hand.
module tb_mux_scan_ctrl;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start, stop;
    logic [1:0] mode, chan;
    logic [3:0] chans;                 // bit i = value presented on channel i

    logic       mux_z [NI];
    logic       sel   [NI];
    logic       grp   [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic [3:0] res   [NI];
    logic [3:0] mask  [NI];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            assign mux_z[gi] = chans[{grp[gi], sel[gi]}];
            mux_scan_ctrl #(.DWELL(gi + 1)) u_dut (
                .clk          (clk),
                .reset        (reset),
                .start        (start),
                .mode         (mode),
                .chan         (chan),
                .stop         (stop),
                .mux_z        (mux_z[gi]),
                .select       (sel[gi]),
                .select_group (grp[gi]),
                .busy         (busy[gi]),
                .done         (done[gi]),
                .result       (res[gi]),
                .valid_mask   (mask[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: a run is a list of steps of DWELL+1 cycles each; cycle index m_c
    // counts cycles since the accepted start edge.
    bit         m_act  [NI];
    bit         m_fin  [NI];
    bit         m_stop [NI];
    int         m_c    [NI];
    logic [1:0] m_mode [NI];
    logic [1:0] m_chan [NI];
    logic [1:0] m_sel  [NI];
    logic [3:0] m_res  [NI];
    logic [3:0] m_mask [NI];
    logic       e_busy [NI];
    logic       e_done [NI];

    always @(posedge clk or posedge reset) begin
        int d, k, q;
        logic [1:0] ch;
        bit last;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_act[i] = 0; m_fin[i] = 0; m_stop[i] = 0; m_c[i] = 0;
                m_mode[i] = 0; m_chan[i] = 0; m_sel[i] = 0;
                m_res[i] = 0; m_mask[i] = 0; e_busy[i] = 0; e_done[i] = 0;
            end else begin
                d = i + 1;
                e_done[i] = 0;
                if (m_fin[i]) begin
                    m_fin[i]  = 0;
                    m_stop[i] = 0;
                end else if (!m_act[i]) begin
                    if (start) begin
                        m_act[i]  = 1;
                        m_mode[i] = (mode == 2'b11) ? 2'b00 : mode;
                        m_chan[i] = chan;
                        m_sel[i]  = (mode == 2'b01) ? chan : 2'd0;
                        m_res[i]  = 0;
                        m_mask[i] = 0;
                        m_stop[i] = 0;
                        m_c[i]    = 1;
                        e_busy[i] = 1;
                    end
                end else begin
                    k  = (m_c[i] - 1) / (d + 1);
                    q  = (m_c[i] - 1) % (d + 1);
                    ch = (m_mode[i] == 2'b01) ? m_chan[i] : 2'(k % 4);
                    if (q == d) begin
                        m_res[i][ch]  = chans[ch];
                        m_mask[i][ch] = 1'b1;
                        last = (m_mode[i] == 2'b01) || (ch == 2'd3 && (m_mode[i] == 2'b00 || m_stop[i]));
                        if (last) begin
                            m_act[i]  = 0;
                            m_fin[i]  = 1;
                            e_busy[i] = 0;
                            e_done[i] = 1;
                        end else begin
                            m_sel[i] = 2'((k + 1) % 4);
                            if (ch == 2'd3) e_done[i] = 1;
                        end
                    end
                    if (m_mode[i] == 2'b10 && stop) m_stop[i] = 1;
                    m_c[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("model_cmp_dwell%0d {sg,s,busy,done,result,mask}", i + 1),
                    {20'd0, grp[i], sel[i], busy[i], done[i], res[i], mask[i]},
                    {20'd0, m_sel[i], e_busy[i], e_done[i], m_res[i], m_mask[i]});
            end
        end
    end

    task automatic do_start(input logic [1:0] m, input logic [1:0] c);
        @(negedge clk); #1;
        start = 1'b1; mode = m; chan = c;
        @(negedge clk); #1;
        start = 1'b0;
        $display("start mode=%0d chan=%0d at t=%0t", m, c, $time);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int n = 0; n < 100 && !idle; n++) begin
            @(negedge clk); #1;
            idle = 1;
            for (int i = 0; i < NI; i++) if (busy[i] || done[i]) idle = 0;
        end
        chk("wait_idle_timeout", {31'd0, !idle}, 32'd0);
        @(negedge clk); #1;
    endtask

    initial begin
        int busy_cnt, done_cnt, done_at;
        start = 0; stop = 0; mode = 0; chan = 0; chans = 4'b1101;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs_dwell1", {20'd0, grp[0], sel[0], busy[0], done[0], res[0], mask[0]}, 32'd0);
        #1 reset = 1'b0;

        // Reset in ch1 SETTLE (DWELL=1): outputs clear without a clock edge
        do_start(2'b00, 2'd0);
        repeat (2) begin @(negedge clk); #1; end
        chk("t1_mask_before_reset", {28'd0, mask[0]}, 32'h1);
        chk("t1_sel_before_reset", {30'd0, grp[0], sel[0]}, 32'd1);
        reset = 1'b1; #1;
        for (int i = 0; i < NI; i++)
            chk($sformatf("t1_async_clear_dwell%0d", i + 1),
                {20'd0, grp[i], sel[i], busy[i], done[i], res[i], mask[i]}, 32'd0);
        @(negedge clk); #1; reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (done[0]) done_cnt++;
            @(negedge clk); #1;
        end
        chk("t1_no_done_after_reset", done_cnt, 0);
        $display("test1 reset mid-run complete");

        // Full scan DWELL=1, ch values 1,0,1,1
        chans = 4'b1101;
        do_start(2'b00, 2'd0);
        busy_cnt = 0; done_at = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c % 2 == 1 && c <= 7) chk($sformatf("t2_sel_cycle%0d", c), {30'd0, grp[0], sel[0]}, (c - 1) / 2);
            if (busy[0]) busy_cnt++;
            if (done[0] && done_at == 0) done_at = c;
            @(negedge clk); #1;
        end
        chk("t2_busy_cycles", busy_cnt, 8);
        chk("t2_done_cycle", done_at, 9);
        chk("t2_result", {28'd0, res[0]}, 32'hD);
        chk("t2_valid_mask", {28'd0, mask[0]}, 32'hF);
        wait_idle();
        $display("test2 full scan complete");

        // Start with mode 01 mid-scan is ignored
        do_start(2'b00, 2'd0);
        busy_cnt = 0; done_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            start = (c == 3); mode = (c == 3) ? 2'b01 : 2'b00; chan = (c == 3) ? 2'd3 : 2'd0;
            if (busy[0]) busy_cnt++;
            if (done[0]) done_cnt++;
            @(negedge clk); #1;
        end
        start = 0;
        chk("t5_busy_cycles", busy_cnt, 8);
        chk("t5_done_count", done_cnt, 1);
        chk("t5_result", {28'd0, res[0]}, 32'hD);
        chk("t5_idle_after", {31'd0, busy[0]}, 32'd0);
        wait_idle();
        $display("test5 ignored start complete");

        // Single channel DWELL=3, chan 2
        chans = 4'b0100;
        do_start(2'b01, 2'd2);
        done_at = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 4) chk($sformatf("t3_sel_busy_cycle%0d", c), {29'd0, grp[2], sel[2], busy[2]}, 32'b101);
            if (done[2] && done_at == 0) done_at = c;
            @(negedge clk); #1;
        end
        chk("t3_done_cycle", done_at, 5);
        chk("t3_result", {28'd0, res[2]}, 32'h4);
        chk("t3_valid_mask", {28'd0, mask[2]}, 32'h4);
        wait_idle();
        $display("test3 single channel complete");

        // Reserved mode 11 behaves as scan, DWELL=2
        chans = 4'b1010;
        do_start(2'b11, 2'd1);
        done_at = 0;
        for (int c = 1; c <= 16; c++) begin
            if (done[1] && done_at == 0) done_at = c;
            @(negedge clk); #1;
        end
        chk("t6_done_cycle", done_at, 13);
        chk("t6_result", {28'd0, res[1]}, 32'hA);
        chk("t6_valid_mask", {28'd0, mask[1]}, 32'hF);
        wait_idle();
        $display("test6 reserved mode complete");

        // Continuous DWELL=1, data changes after sweep 1, stop in sweep 2 ch1
        chans = 4'b1101;
        do_start(2'b10, 2'd0);
        for (int c = 1; c <= 20; c++) begin
            if (c == 9) chans = 4'b0010;
            stop = (c == 11);
            if (c == 9)  chk("t4_wrap_done_busy", {30'd0, done[0], busy[0]}, 32'b11);
            if (c == 9)  chk("t4_wrap_result", {28'd0, res[0]}, 32'hD);
            if (c == 17) chk("t4_finish_done_busy", {30'd0, done[0], busy[0]}, 32'b10);
            if (c == 17) chk("t4_final_result", {28'd0, res[0]}, 32'h2);
            if (c == 17) chk("t4_final_mask", {28'd0, mask[0]}, 32'hF);
            if (c == 18) chk("t4_idle_after", {30'd0, done[0], busy[0]}, 32'b00);
            @(negedge clk); #1;
        end
        stop = 0;
        wait_idle();
        $display("test4 continuous with stop complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
